// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Divisor clamp keeps the counter range legal (minimum divide-by-2).
package clk_div_pkg;

  localparam int DIV_W   = 8;
  localparam int MIN_DIV = 2;

  typedef logic [DIV_W-1:0] div_t;

  function automatic div_t clamp_div(div_t d);
    return (d < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clk_div_negedge_stage.sv
// Single falling-edge flop for the 50%-duty odd-divisor path.
// Kept alone so the mixed-edge timing can be constrained in isolation.
module clk_div_negedge_stage (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with clock-enable strobe.
// Define CLK_DIV_DUTY50_EN for exact 50% duty on odd divisors.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W           = DIV_W,
  parameter int DIV_DEFAULT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         clk_out,
  output logic         ce_pulse,
  output logic         div_ack,
  output logic [W-1:0] div_active
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] div_q;
  logic [W-1:0] div_nxt;
  logic [W-1:0] pend;
  logic [W-1:0] load_val;
  logic [W-1:0] half;
  logic         pend_vld;
  logic         term;
  logic         apply;
  logic         run_nxt;
  logic         p;
  logic         p_nxt;

  generate
    if (W == DIV_W) begin : g_pkg_clamp
      assign load_val = clamp_div(div_in);
    end else begin : g_gen_clamp
      assign load_val = (div_in < W'(MIN_DIV)) ? W'(MIN_DIV) : div_in;
    end
  endgenerate

  always_comb begin
    term    = (cnt == div_q - W'(1));
    apply   = term && (pend_vld || div_load);
    div_nxt = div_q;
    if (apply) div_nxt = div_load ? load_val : pend;
    cnt_nxt = cnt + W'(1);
    run_nxt = 1'b1;
    if (term) begin
      run_nxt = en;
      cnt_nxt = en ? '0 : div_nxt - W'(1);
    end
    // ceil(N/2) without overflowing at the top of the range
    half  = (div_nxt >> 1) + W'(div_nxt[0]);
    p_nxt = run_nxt && (cnt_nxt < half);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= W'(DIV_DEFAULT - 1);
      div_q    <= W'(DIV_DEFAULT);
      pend     <= '0;
      pend_vld <= 1'b0;
      p        <= 1'b0;
      ce_pulse <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_q    <= div_nxt;
      p        <= p_nxt;
      ce_pulse <= term && en;
      div_ack  <= apply;
      if (apply) begin
        pend_vld <= 1'b0;
      end else if (div_load) begin
        pend     <= load_val;
        pend_vld <= 1'b1;
      end
    end
  end

  assign div_active = div_q;

`ifdef CLK_DIV_DUTY50_EN
  logic n;

  clk_div_negedge_stage u_neg (
    .clk   (clk),
    .reset (reset),
    .d     (p),
    .q     (n)
  );

  assign clk_out = div_q[0] ? (p & n) : p;
`else
  assign clk_out = p;
`endif

endmodule
